// File: rtl/ds_adc_pkg.sv
// ds_adc_pkg: shared state type and sizing helper for the delta-sigma conversion controller.
package ds_adc_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_ADC_RST, ST_SETTLE, ST_ACCUM} ds_ctrl_state_t;
    function automatic int acc_width(input int width, input int avg_log2);
        return width + avg_log2;
    endfunction
endpackage

// File: rtl/ds_avg_accum.sv
// ds_avg_accum: signed sample accumulator that emits the floor average of 2^AVG_LOG2 samples.
module ds_avg_accum
    import ds_adc_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int AVG_LOG2 = 3
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [WIDTH-1:0] din,
    output logic                    done,
    output logic signed [WIDTH-1:0] avg
);
    localparam int AW = acc_width(WIDTH, AVG_LOG2);
    localparam int CW = AVG_LOG2 + 1;
    logic signed [AW-1:0] acc_q, acc_d, sum;
    logic [CW-1:0] cnt_q, cnt_d;
    // The final sample is folded into the average directly so the result is ready on its strobe.
    always_comb begin
        sum   = acc_q + AW'(din);
        done  = en && (cnt_q == CW'((1 << AVG_LOG2) - 1));
        avg   = WIDTH'(sum >>> AVG_LOG2);
        acc_d = (clr || done) ? '0 : en ? sum : acc_q;
        cnt_d = (clr || done) ? '0 : en ? cnt_q + CW'(1) : cnt_q;
    end
    always_ff @(posedge clk) begin
        if (!rstn) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/ds_adc_conv_ctrl.sv
// ds_adc_conv_ctrl: sequences ADC reset, settling discard and averaging, and hands results
// to the consumer over valid/ready with a sticky overrun flag.
module ds_adc_conv_ctrl
    import ds_adc_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int RST_CYC  = 4,
    parameter int SETTLE   = 4,
    parameter int AVG_LOG2 = 3
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic                    cont_mode,
    input  logic                    abort,
    input  logic                    dig_valid,
    input  logic signed [WIDTH-1:0] dig_out,
    output logic                    adc_rstn,
    output logic                    busy,
    output logic signed [WIDTH-1:0] result,
    output logic                    result_valid,
    input  logic                    result_ready,
    output logic                    overrun
);
    localparam int PW = $clog2((RST_CYC > SETTLE ? RST_CYC : SETTLE) + 1);
    ds_ctrl_state_t state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic cont_q, cont_d, adc_rstn_q, adc_rstn_d;
    logic result_valid_q, result_valid_d, overrun_q, overrun_d;
    logic signed [WIDTH-1:0] result_q, result_d, acc_avg;
    logic acc_en, acc_clr, acc_done;

    ds_avg_accum #(.WIDTH(WIDTH), .AVG_LOG2(AVG_LOG2)) u_accum (
        .clk  (clk),
        .rstn (rstn),
        .clr  (acc_clr),
        .en   (acc_en),
        .din  (dig_out),
        .done (acc_done),
        .avg  (acc_avg)
    );

    always_comb begin
        state_d        = state_q;
        phase_d        = phase_q;
        cont_d         = cont_q;
        result_d       = result_q;
        result_valid_d = result_valid_q && !result_ready;
        overrun_d      = overrun_q;
        acc_en         = state_q == ST_ACCUM && dig_valid && !abort;
        acc_clr        = abort || (state_q == ST_IDLE && start);
        if (abort) begin
            state_d = ST_IDLE;
            phase_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: if (start) begin
                    state_d   = ST_ADC_RST;
                    phase_d   = '0;
                    cont_d    = cont_mode;
                    overrun_d = 1'b0;
                end
                ST_ADC_RST: begin
                    state_d = (phase_q == PW'(RST_CYC - 1)) ? ((SETTLE == 0) ? ST_ACCUM : ST_SETTLE) : ST_ADC_RST;
                    phase_d = (phase_q == PW'(RST_CYC - 1)) ? '0 : phase_q + PW'(1);
                end
                ST_SETTLE: if (dig_valid) begin
                    state_d = (phase_q == PW'(SETTLE - 1)) ? ST_ACCUM : ST_SETTLE;
                    phase_d = (phase_q == PW'(SETTLE - 1)) ? '0 : phase_q + PW'(1);
                end
                ST_ACCUM: if (acc_done) begin
                    state_d        = cont_q ? ST_ACCUM : ST_IDLE;
                    result_d       = acc_avg;
                    result_valid_d = 1'b1;
                    // Overwriting an unconsumed result is only an overrun if it was not taken this cycle.
                    overrun_d      = overrun_q || (result_valid_q && !result_ready);
                end
                default: state_d = ST_IDLE;
            endcase
        end
        adc_rstn_d = state_d == ST_SETTLE || state_d == ST_ACCUM;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q        <= ST_IDLE;
            phase_q        <= '0;
            cont_q         <= 1'b0;
            adc_rstn_q     <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            cont_q         <= cont_d;
            adc_rstn_q     <= adc_rstn_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            overrun_q      <= overrun_d;
        end
    end

    assign adc_rstn     = adc_rstn_q;
    assign busy         = state_q != ST_IDLE;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign overrun      = overrun_q;
endmodule

// File: tb/tb_ds_adc_conv_ctrl.sv
// tb_ds_adc_conv_ctrl: scenario tasks with randomized samples checked against a floor-average model.
module tb_ds_adc_conv_ctrl;
    localparam int W = 8, RC = 4, ST = 4, AL = 3, N = 1 << AL;
    logic clk = 1'b0, rstn, start, cont_mode, abort, dig_valid, result_ready;
    logic signed [W-1:0] dig_out, result;
    logic adc_rstn, busy, result_valid, overrun;
    int total = 0, bad = 0;

    ds_adc_conv_ctrl #(.WIDTH(W), .RST_CYC(RC), .SETTLE(ST), .AVG_LOG2(AL)) dut (
        .clk(clk), .rstn(rstn), .start(start), .cont_mode(cont_mode), .abort(abort),
        .dig_valid(dig_valid), .dig_out(dig_out), .adc_rstn(adc_rstn), .busy(busy),
        .result(result), .result_valid(result_valid), .result_ready(result_ready), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic signed [W-1:0] v, input logic rdy);
        repeat ($urandom_range(0, 2)) tick();
        dig_valid = 1'b1;
        dig_out = v;
        result_ready = rdy;
        tick();
        dig_valid = 1'b0;
        result_ready = 1'b0;
        dig_out = W'($urandom);
    endtask

    function automatic int floor_div(input int s, input int d);
        return (s >= 0) ? s / d : -((-s + d - 1) / d);
    endfunction

    function automatic logic signed [W-1:0] sample(input int mode, input int i);
        case (mode)
            0: return 8'sd15;
            1: return (i % 2) ? -8'sd4 : -8'sd3;
            2: return (i % 2) ? 8'sd4 : 8'sd3;
            3: return -8'sd128;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic begin_conv(input logic cm, output int rst_low);
        start = 1'b1;
        cont_mode = cm;
        tick();
        start = 1'b0;
        cont_mode = 1'($urandom);
        rst_low = 0;
        while (!adc_rstn && rst_low < 20) begin
            rst_low++;
            tick();
        end
    endtask

    task automatic settle();
        repeat (ST) strobe(W'($urandom), 1'b0);
    endtask

    task automatic accumulate(input int mode, input logic rdy_last, output int exp);
        int s = 0;
        logic signed [W-1:0] v;
        for (int i = 0; i < N; i++) begin
            v = sample(mode, i);
            s += int'(v);
            strobe(v, (i == N - 1) ? rdy_last : 1'b0);
        end
        exp = floor_div(s, N);
    endtask

    task automatic test_reset();
        rstn = 1'b0; start = 0; cont_mode = 0; abort = 0; dig_valid = 0; dig_out = '0; result_ready = 0;
        tick(); tick();
        total += 5;
        if (adc_rstn !== 1'b0) begin bad++; $display("FAIL reset_adc_rstn got=%0b want=0", adc_rstn); end
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
        if (result !== '0) begin bad++; $display("FAIL reset_result got=%0d want=0", result); end
        if (result_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", result_valid); end
        if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%0b want=0", overrun); end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_single(input int mode);
        int rl, exp;
        begin_conv(1'b0, rl);
        total += 2;
        if (rl !== RC) begin bad++; $display("FAIL single_rst_cycles m%0d got=%0d want=%0d", mode, rl, RC); end
        if (busy !== 1'b1) begin bad++; $display("FAIL single_busy m%0d got=%0b want=1", mode, busy); end
        settle();
        accumulate(mode, 1'b0, exp);
        total += 5;
        if (result_valid !== 1'b1) begin bad++; $display("FAIL single_valid m%0d got=%0b want=1", mode, result_valid); end
        if (int'(result) !== exp) begin bad++; $display("FAIL single_result m%0d got=%0d want=%0d", mode, result, exp); end
        if (busy !== 1'b0) begin bad++; $display("FAIL single_idle m%0d got=%0b want=0", mode, busy); end
        if (overrun !== 1'b0) begin bad++; $display("FAIL single_overrun m%0d got=%0b want=0", mode, overrun); end
        if (adc_rstn !== 1'b0) begin bad++; $display("FAIL single_adc_rstn m%0d got=%0b want=0", mode, adc_rstn); end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        total++;
        if (result_valid !== 1'b0) begin bad++; $display("FAIL single_consume m%0d got=%0b want=0", mode, result_valid); end
    endtask

    task automatic test_continuous_overrun();
        int rl, e1, e2;
        begin_conv(1'b1, rl);
        settle();
        accumulate(4, 1'b0, e1);
        total += 3;
        if (int'(result) !== e1) begin bad++; $display("FAIL cont_first got=%0d want=%0d", result, e1); end
        if (overrun !== 1'b0) begin bad++; $display("FAIL cont_first_overrun got=%0b want=0", overrun); end
        if (busy !== 1'b1) begin bad++; $display("FAIL cont_busy got=%0b want=1", busy); end
        accumulate(4, 1'b0, e2);
        total += 4;
        if (int'(result) !== e2) begin bad++; $display("FAIL cont_overwrite got=%0d want=%0d", result, e2); end
        if (result_valid !== 1'b1) begin bad++; $display("FAIL cont_valid got=%0b want=1", result_valid); end
        if (overrun !== 1'b1) begin bad++; $display("FAIL cont_overrun got=%0b want=1", overrun); end
        if (adc_rstn !== 1'b1) begin bad++; $display("FAIL cont_no_rereset got=%0b want=1", adc_rstn); end
        repeat (3) tick();
        total++;
        if (int'(result) !== e2) begin bad++; $display("FAIL cont_stable got=%0d want=%0d", result, e2); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total += 3;
        if (busy !== 1'b0) begin bad++; $display("FAIL cont_abort_busy got=%0b want=0", busy); end
        if (result_valid !== 1'b1) begin bad++; $display("FAIL cont_abort_valid got=%0b want=1", result_valid); end
        if (overrun !== 1'b1) begin bad++; $display("FAIL cont_abort_overrun got=%0b want=1", overrun); end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
    endtask

    task automatic test_same_cycle_consume();
        int rl, e1, e2;
        overrun_seed: begin end
        begin_conv(1'b1, rl);
        total++;
        if (overrun !== 1'b0) begin bad++; $display("FAIL sc_start_clears_overrun got=%0b want=0", overrun); end
        settle();
        accumulate(4, 1'b0, e1);
        total++;
        if (int'(result) !== e1) begin bad++; $display("FAIL sc_first got=%0d want=%0d", result, e1); end
        accumulate(4, 1'b1, e2);
        total += 3;
        if (result_valid !== 1'b1) begin bad++; $display("FAIL sc_valid got=%0b want=1", result_valid); end
        if (int'(result) !== e2) begin bad++; $display("FAIL sc_result got=%0d want=%0d", result, e2); end
        if (overrun !== 1'b0) begin bad++; $display("FAIL sc_overrun got=%0b want=0", overrun); end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total += 2;
        if (result_valid !== 1'b0) begin bad++; $display("FAIL sc_consume got=%0b want=0", result_valid); end
        if (busy !== 1'b0) begin bad++; $display("FAIL sc_abort got=%0b want=0", busy); end
    endtask

    task automatic test_abort();
        int rl;
        begin_conv(1'b0, rl);
        settle();
        repeat (5) strobe(W'($urandom), 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total += 3;
        if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%0b want=0", busy); end
        if (adc_rstn !== 1'b0) begin bad++; $display("FAIL abort_adc_rstn got=%0b want=0", adc_rstn); end
        if (result_valid !== 1'b0) begin bad++; $display("FAIL abort_valid got=%0b want=0", result_valid); end
        repeat (3) strobe(W'($urandom), 1'b0);
        total++;
        if (result_valid !== 1'b0) begin bad++; $display("FAIL abort_idle_strobes got=%0b want=0", result_valid); end
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL abort_beats_start got=%0b want=0", busy); end
        test_single(4);
    endtask

    task automatic test_reset_mid();
        int rl, exp;
        begin_conv(1'b0, rl);
        settle();
        accumulate(4, 1'b0, exp);
        begin_conv(1'b0, rl);
        strobe(W'($urandom), 1'b0);
        strobe(W'($urandom), 1'b0);
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (adc_rstn !== 1'b1) begin bad++; $display("FAIL busy_start_glitch c%0d got=%0b want=1", i, adc_rstn); end
        end
        start = 1'b0;
        total++;
        if (int'(result) !== exp) begin bad++; $display("FAIL mid_result_held got=%0d want=%0d", result, exp); end
        rstn = 1'b0;
        tick();
        total += 5;
        if (adc_rstn !== 1'b0) begin bad++; $display("FAIL mid_reset_adc_rstn got=%0b want=0", adc_rstn); end
        if (busy !== 1'b0) begin bad++; $display("FAIL mid_reset_busy got=%0b want=0", busy); end
        if (result !== '0) begin bad++; $display("FAIL mid_reset_result got=%0d want=0", result); end
        if (result_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_valid got=%0b want=0", result_valid); end
        if (overrun !== 1'b0) begin bad++; $display("FAIL mid_reset_overrun got=%0b want=0", overrun); end
        rstn = 1'b1;
        tick();
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL mid_reset_stays_idle got=%0b want=0", busy); end
    endtask

    initial begin
        test_reset();
        test_single(0);
        test_single(1);
        test_single(2);
        test_single(3);
        test_single(4);
        test_single(4);
        test_continuous_overrun();
        test_same_cycle_consume();
        test_abort();
        test_reset_mid();
        test_single(4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
